i2c_register_poller: RTL and testbench

//  Autonomous I2C register scanner that drives the control side of i2c_master.
//  It sweeps a parameterised list of 8-bit registers on one 7-bit device. Each register takes a

---
 rtl/i2c_register_poller.sv | 178 +++++++++++++++++
 tb/tb_i2c_register_poller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_register_poller.sv
// Autonomous I2C register scanner: sweeps REG_LIST on one device through i2c_master,
// doing a pointer write then a 1-byte read per entry, with retry, timeout and poll interval.
module i2c_register_poller #(
    parameter logic [6:0]            DEVICE_ADDR   = 7'h6B,
    parameter int unsigned           NUM_REGS      = 4,
    // entry i occupies REG_LIST[i*8 +: 8]; entry 0 (reg 08) sits in the low byte
    parameter logic [NUM_REGS*8-1:0] REG_LIST      = {8'h01, 8'h00, 8'h09, 8'h08},
    parameter int unsigned           POLL_INTERVAL = 48000,
    parameter int unsigned           MAX_RETRIES   = 2,
    parameter int unsigned           TIMEOUT       = 480000
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    enable,
    output logic [7:0]              address,
    output logic                    transfer_start,
    output logic                    transfer_continues,
    output logic [7:0]              data_tx,
    input  logic                    transfer_ready,
    input  logic                    interrupt,
    input  logic                    transaction_complete,
    input  logic                    nack,
    input  logic [7:0]              data_rx,
    output logic [NUM_REGS*8-1:0]   reg_values,
    output logic [NUM_REGS-1:0]     reg_valid,
    output logic                    update_strobe,
    output logic [3:0]              update_index,
    output logic                    error
);

    localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned IVL_W    = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int unsigned RTY_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);
    localparam logic [7:0]  ADDR_WR  = {DEVICE_ADDR, 1'b0};
    localparam logic [7:0]  ADDR_RD  = {DEVICE_ADDR, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WR,
        WAIT_WR,
        ISSUE_RD,
        WAIT_RD,
        NEXT,
        INTERVAL
    } state_t;

    state_t             state;
    logic [3:0]         index;
    logic [RTY_W-1:0]   retry;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [IVL_W-1:0]   ivl_cnt;

    logic               xfer_ok;
    logic               xfer_fail;
    logic               can_retry;

    // Register pointer for a given sweep index.
    function automatic logic [7:0] reg_ptr(input logic [3:0] idx);
        reg_ptr = 8'h00;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) reg_ptr = REG_LIST[i*8 +: 8];
        end
    endfunction

    // An interrupt outcome takes precedence over a simultaneous timeout.
    assign xfer_ok   = interrupt && transaction_complete && !nack;
    assign xfer_fail = interrupt ? !(transaction_complete && !nack)
                                 : (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign can_retry = (retry < RTY_W'(MAX_RETRIES));

    assign transfer_continues = 1'b0;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state          <= IDLE;
            index          <= 4'd0;
            retry          <= '0;
            tmo_cnt        <= '0;
            ivl_cnt        <= '0;
            address        <= ADDR_WR;
            data_tx        <= 8'h00;
            transfer_start <= 1'b0;
            reg_values     <= '0;
            reg_valid      <= '0;
            update_strobe  <= 1'b0;
            update_index   <= 4'd0;
            error          <= 1'b0;
        end else begin
            transfer_start <= 1'b0;
            update_strobe  <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        index   <= 4'd0;
                        address <= ADDR_WR;
                        data_tx <= reg_ptr(4'd0);
                        state   <= ISSUE_WR;
                    end
                end

                ISSUE_WR: begin
                    if (transfer_ready) begin
                        transfer_start <= 1'b1;
                        tmo_cnt        <= '0;
                        state          <= WAIT_WR;
                    end
                end

                ISSUE_RD: begin
                    if (transfer_ready) begin
                        transfer_start <= 1'b1;
                        tmo_cnt        <= '0;
                        state          <= WAIT_RD;
                    end
                end

                WAIT_WR, WAIT_RD: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (xfer_ok && (state == WAIT_WR)) begin
                        address <= ADDR_RD;
                        state   <= ISSUE_RD;
                    end else if (xfer_ok) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (index == 4'(i)) begin
                                reg_values[i*8 +: 8] <= data_rx;
                                reg_valid[i]         <= 1'b1;
                            end
                        end
                        update_strobe <= 1'b1;
                        update_index  <= index;
                        retry         <= '0;
                        state         <= NEXT;
                    end else if (xfer_fail && can_retry) begin
                        // Any failure, read included, restarts with the pointer write.
                        retry   <= retry + RTY_W'(1);
                        address <= ADDR_WR;
                        state   <= ISSUE_WR;
                    end else if (xfer_fail) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (index == 4'(i)) reg_valid[i] <= 1'b0;
                        end
                        error         <= 1'b1;
                        update_strobe <= 1'b1;
                        update_index  <= index;
                        retry         <= '0;
                        state         <= NEXT;
                    end
                end

                NEXT: begin
                    if (index == LAST_IDX) begin
                        index   <= 4'd0;
                        ivl_cnt <= '0;
                        state   <= INTERVAL;
                    end else begin
                        index   <= index + 4'd1;
                        address <= ADDR_WR;
                        data_tx <= reg_ptr(index + 4'd1);
                        state   <= ISSUE_WR;
                    end
                end

                INTERVAL: begin
                    if (ivl_cnt == IVL_W'(POLL_INTERVAL - 1)) begin
                        state <= IDLE;
                    end else begin
                        ivl_cnt <= ivl_cnt + IVL_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_register_poller.sv
// Directed bench for i2c_register_poller: a small i2c_master/slave model answers each
// transfer, and sweeps are checked against hand-computed start sequences and register images.
module tb_i2c_register_poller;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  address;
    logic        transfer_start;
    logic        transfer_continues;
    logic [7:0]  data_tx;
    logic        transfer_ready;
    logic        interrupt;
    logic        transaction_complete;
    logic        nack;
    logic [7:0]  data_rx;
    logic [31:0] reg_values;
    logic [3:0]  reg_valid;
    logic        update_strobe;
    logic [3:0]  update_index;
    logic        error;

    always #5 clk_in = ~clk_in;

    i2c_register_poller #(
        .DEVICE_ADDR   (7'h6B),
        .NUM_REGS      (4),
        .REG_LIST      (32'h01000908),
        .POLL_INTERVAL (50),
        .MAX_RETRIES   (2),
        .TIMEOUT       (100)
    ) dut (
        .clk_in               (clk_in),
        .reset                (reset),
        .enable               (enable),
        .address              (address),
        .transfer_start       (transfer_start),
        .transfer_continues   (transfer_continues),
        .data_tx              (data_tx),
        .transfer_ready       (transfer_ready),
        .interrupt            (interrupt),
        .transaction_complete (transaction_complete),
        .nack                 (nack),
        .data_rx              (data_rx),
        .reg_values           (reg_values),
        .reg_valid            (reg_valid),
        .update_strobe        (update_strobe),
        .update_index         (update_index),
        .error                (error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observation logs
    logic [15:0] st_log[$];
    int          st_cyc[$];
    logic [3:0]  up_idx[$];
    int          up_cyc[$];
    int          cyc = 0;
    int          viol = 0;
    logic        rdy_at_edge = 1'b1;
    logic        prev_start = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk_in);
        rdy_at_edge = transfer_ready;
    end

    // Start/update monitor; a start must be one cycle wide and issued only with ready high.
    initial forever begin
        @(negedge clk_in);
        if (transfer_start) begin
            st_log.push_back({address, data_tx});
            st_cyc.push_back(cyc);
            if (!rdy_at_edge) viol++;
            if (prev_start) viol++;
        end
        prev_start = transfer_start;
        if (update_strobe) begin
            up_idx.push_back(update_index);
            up_cyc.push_back(cyc);
        end
    end

    // Master + slave model
    logic [7:0] mem [256];
    logic [7:0] cur_ptr;
    logic [7:0] dead_reg;
    bit         dead_en = 1'b0;
    bit         nack_rd09 = 1'b0;
    int         silent_holds[$];

    initial begin
        int         hold;
        logic       is_rd;
        logic [7:0] ptr;
        transfer_ready       = 1'b1;
        interrupt            = 1'b0;
        transaction_complete = 1'b0;
        nack                 = 1'b0;
        data_rx              = 8'h00;
        cur_ptr              = 8'h00;
        forever begin
            @(negedge clk_in);
            if (transfer_start && !reset) begin
                is_rd = address[0];
                ptr   = data_tx;
                transfer_ready = 1'b0;
                if (!is_rd && ptr == 8'h08 && silent_holds.size() > 0) begin
                    hold = silent_holds.pop_front();
                    repeat (hold) @(negedge clk_in);
                end else begin
                    repeat (3) @(negedge clk_in);
                    interrupt            = 1'b1;
                    transaction_complete = 1'b1;
                    if (is_rd) begin
                        data_rx = mem[cur_ptr];
                        nack    = nack_rd09 && (cur_ptr == 8'h09);
                        if (nack) nack_rd09 = 1'b0;
                    end else begin
                        nack = dead_en && (ptr == dead_reg);
                        if (!nack) cur_ptr = ptr;
                    end
                    @(negedge clk_in);
                    interrupt            = 1'b0;
                    transaction_complete = 1'b0;
                    nack                 = 1'b0;
                end
                transfer_ready = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        st_log.delete();
        st_cyc.delete();
        up_idx.delete();
        up_cyc.delete();
    endtask

    task automatic wait_starts(input int n);
        int k = 0;
        while (st_log.size() < n && k < 4000) begin
            tick();
            k++;
        end
        check_eq($sformatf("wait_starts_%0d", n), 64'(st_log.size() >= n), 64'd1);
    endtask

    task automatic wait_updates(input int n);
        int k = 0;
        while (up_idx.size() < n && k < 4000) begin
            tick();
            k++;
        end
        check_eq($sformatf("wait_updates_%0d", n), 64'(up_idx.size() >= n), 64'd1);
    endtask

    // One sweep with enable dropped once the reg-1 pointer write has started.
    task automatic run_sweep();
        clear_logs();
        enable = 1'b1;
        wait_starts(3);
        enable = 1'b0;
        wait_updates(4);
        idle(150);
    endtask

    task automatic check_addr(input int i, input logic [7:0] exp);
        logic [15:0] e;
        e = (i < st_log.size()) ? st_log[i] : 16'h0000;
        check_eq($sformatf("start%0d_addr", i), 64'(e[15:8]), 64'(exp));
    endtask

    task automatic check_wr(input int i, input logic [7:0] ptr);
        logic [15:0] e;
        e = (i < st_log.size()) ? st_log[i] : 16'h0000;
        check_eq($sformatf("start%0d_wr", i), 64'(e), 64'({8'hD6, ptr}));
    endtask

    initial begin
        logic [7:0] ptrs [4];
        ptrs[0] = 8'h08; ptrs[1] = 8'h09; ptrs[2] = 8'h00; ptrs[3] = 8'h01;
        mem[8'h08] = 8'hA5; mem[8'h09] = 8'h3C; mem[8'h00] = 8'h00; mem[8'h01] = 8'hFF;
        dead_reg = 8'h00;
        reset  = 1'b1;
        enable = 1'b0;
        idle(3);
        check_eq("rst_address", 64'(address), 64'hD6);
        check_eq("rst_start", 64'(transfer_start), 64'd0);
        check_eq("rst_continues", 64'(transfer_continues), 64'd0);
        check_eq("rst_values", 64'(reg_values), 64'd0);
        check_eq("rst_valid", 64'(reg_valid), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        reset = 1'b0;
        idle(5);
        check_eq("idle_no_start", 64'(st_log.size()), 64'd0);

        // Happy sweep
        run_sweep();
        check_eq("t1_starts", 64'(st_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check_addr(i, (i % 2 == 1) ? 8'hD7 : 8'hD6);
            if (i % 2 == 0) check_wr(i, ptrs[i/2]);
        end
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t1_upd%0d", i), 64'((i < up_idx.size()) ? up_idx[i] : 4'hF), 64'(i));
        check_eq("t1_values", 64'(reg_values), 64'hFF003CA5);
        check_eq("t1_valid", 64'(reg_valid), 64'hF);
        check_eq("t1_error", 64'(error), 64'd0);

        // Single NACK on the first read of reg 09
        mem[8'h09] = 8'h5A; mem[8'h00] = 8'h77; nack_rd09 = 1'b1;
        run_sweep();
        check_eq("t2_starts", 64'(st_log.size()), 64'd10);
        check_wr(2, 8'h09);
        check_addr(3, 8'hD7);
        check_wr(4, 8'h09);
        check_wr(6, 8'h00);
        check_eq("t2_updates", 64'(up_idx.size()), 64'd4);
        check_eq("t2_values", 64'(reg_values), 64'hFF775AA5);
        check_eq("t2_valid", 64'(reg_valid), 64'hF);
        check_eq("t2_error", 64'(error), 64'd0);

        // Dead register 00
        mem[8'h08] = 8'h11; mem[8'h00] = 8'hEE; dead_en = 1'b1;
        run_sweep();
        dead_en = 1'b0;
        check_eq("t3_starts", 64'(st_log.size()), 64'd9);
        check_wr(4, 8'h00);
        check_wr(5, 8'h00);
        check_wr(6, 8'h00);
        check_wr(7, 8'h01);
        check_eq("t3_updates", 64'(up_idx.size()), 64'd4);
        check_eq("t3_upd2", 64'((up_idx.size() > 2) ? up_idx[2] : 4'hF), 64'd2);
        check_eq("t3_values", 64'(reg_values), 64'hFF775A11);
        check_eq("t3_valid", 64'(reg_valid), 64'hB);
        check_eq("t3_error", 64'(error), 64'd1);

        // Timeout on write 08, twice: once ready recovers early, once it stays low past expiry
        silent_holds.push_back(40);
        silent_holds.push_back(150);
        run_sweep();
        check_eq("t4_starts", 64'(st_log.size()), 64'd10);
        check_wr(0, 8'h08);
        check_wr(1, 8'h08);
        check_wr(2, 8'h08);
        check_eq("t4_gap_timeout", 64'((st_cyc.size() > 1) ? st_cyc[1] - st_cyc[0] : 0), 64'd101);
        check_eq("t4_gap_ready_low", 64'((st_cyc.size() > 2) ? st_cyc[2] - st_cyc[1] : 0), 64'd151);
        check_eq("t4_values", 64'(reg_values), 64'hFFEE5A11);
        check_eq("t4_valid", 64'(reg_valid), 64'hF);
        check_eq("t4_error_sticky", 64'(error), 64'd1);

        // Back-to-back sweeps with enable held, then enable dropped during reg 1
        clear_logs();
        enable = 1'b1;
        wait_updates(4);
        wait_starts(9);
        check_eq("t5_interval_gap", 64'((st_cyc.size() > 8 && up_cyc.size() > 3) ? st_cyc[8] - up_cyc[3] : 0), 64'd53);
        check_wr(8, 8'h08);
        wait_starts(11);
        enable = 1'b0;
        wait_updates(8);
        idle(150);
        check_eq("t5_starts", 64'(st_log.size()), 64'd16);
        check_eq("t5_upd4", 64'((up_idx.size() > 4) ? up_idx[4] : 4'hF), 64'd0);

        // Reset while waiting on the read of reg 2
        clear_logs();
        enable = 1'b1;
        wait_starts(6);
        check_addr(5, 8'hD7);
        reset = 1'b1;
        tick();
        check_eq("t6_address", 64'(address), 64'hD6);
        check_eq("t6_start", 64'(transfer_start), 64'd0);
        check_eq("t6_values", 64'(reg_values), 64'd0);
        check_eq("t6_valid", 64'(reg_valid), 64'd0);
        check_eq("t6_error", 64'(error), 64'd0);
        check_eq("t6_strobe", 64'(update_strobe), 64'd0);
        reset = 1'b0;
        clear_logs();
        wait_starts(1);
        enable = 1'b0;
        check_wr(0, 8'h08);
        wait_updates(4);
        idle(150);
        check_eq("t6_upd0", 64'((up_idx.size() > 0) ? up_idx[0] : 4'hF), 64'd0);
        check_eq("t6_values_after", 64'(reg_values), 64'hFFEE5A11);
        check_eq("t6_valid_after", 64'(reg_valid), 64'hF);
        check_eq("t6_error_after", 64'(error), 64'd0);

        check_eq("start_protocol", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
